// File: rtl/demux_pkg.sv
// Shared definitions for n_way_stream_demux: FSM state encoding and the
// select-width helper used to size SELECT from the channel count.
package demux_pkg;

  // Packet-routing states: IDLE samples SELECT, BURST follows the locked channel.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } demux_state_e;

  // Width of the channel select field; never narrower than one bit.
  function automatic int sel_bits(input int channels);
    return (channels > 2) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/demux_channel_register.sv
// One output channel of n_way_stream_demux: a single holding register
// (valid/data/last) with valid/ready handshake, plus an optional
// delivered-beat counter enabled by the DEMUX_COUNT_EN macro.
module demux_channel_register #(
  parameter int BITS       = 4,
  parameter int COUNT_BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [BITS-1:0] load_data,
  input  logic            load_last,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic            out_last,
  output logic            free
`ifdef DEMUX_COUNT_EN
  ,
  input  logic                  clear_count,
  output logic [COUNT_BITS-1:0] count
`endif
);

  logic drain;

  // A beat leaves this register on the valid/ready handshake.
  assign drain = out_valid & out_ready;

  // The register can take a new beat when empty or when it is draining now.
  assign free = ~out_valid | out_ready;

  // Holding register: load wins over drain so back-to-back beats sustain full rate.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      out_valid <= 1'b0;
      // NOTE: the data word is reset too, because the outputs must read zero after reset.
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DEMUX_COUNT_EN
  // Delivered-beat counter: wraps naturally, clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clear_count) begin
      count <= '0;
    end else if (drain) begin
      count <= count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/n_way_stream_demux.sv
// n_way_stream_demux: registered, handshaked 1-to-CHANNELS demultiplexer
// with packet-locked routing. SELECT is sampled on the first beat of a
// packet; later beats follow the locked channel until IN_LAST.
// Optional macro DEMUX_COUNT_EN adds per-channel delivered-beat counters
// with COUNT / CLEAR_COUNT ports.
module n_way_stream_demux
  import demux_pkg::*;
#(
  parameter  int BITS       = 4,
  parameter  int CHANNELS   = 4,
  parameter  int COUNT_BITS = 8,
  localparam int SEL_BITS   = sel_bits(CHANNELS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BITS-1:0]                    in_data,
  input  logic                               in_last,
  input  logic [SEL_BITS-1:0]                select,
  output logic [CHANNELS-1:0]                out_valid,
  input  logic [CHANNELS-1:0]                out_ready,
  output logic [CHANNELS-1:0][BITS-1:0]      out_data,
  output logic [CHANNELS-1:0]                out_last,
  output logic                               error
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CHANNELS-1:0][COUNT_BITS-1:0] count,
  input  logic                               clear_count
`endif
);

  localparam logic S_IDLE  = IDLE;
  localparam logic S_BURST = BURST;

  logic                state;
  logic [SEL_BITS-1:0] lock_sel;
  logic [SEL_BITS-1:0] tgt;
  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] load;
  logic                illegal;
  logic                accept;

  // Target channel: live SELECT at packet start, the locked channel mid-packet.
  assign tgt = (state == S_BURST) ? lock_sel : select;

  // A first beat naming a non-existent channel is swallowed and flagged.
  assign illegal = (state == S_IDLE) && in_valid && (32'(select) >= CHANNELS);

  // Ready follows the target channel's free flag; illegal beats are always taken.
  always_comb begin
    // NOTE: default assigned first so no latch is inferred.
    in_ready = illegal;
    for (int c = 0; c < CHANNELS; c++) begin
      if (tgt == SEL_BITS'(c)) in_ready = in_ready | free[c];
    end
  end

  assign accept = in_valid & in_ready;

  // One-hot load strobe into the target channel's holding register.
  always_comb begin
    load = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      load[c] = accept && !illegal && (tgt == SEL_BITS'(c));
    end
  end

  // Packet-lock FSM and sticky illegal-select flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      lock_sel <= '0;
      error    <= 1'b0;
    end else begin
      if (accept && illegal) error <= 1'b1;
      if (state == S_IDLE) begin
        if (accept && !illegal && !in_last) begin
          lock_sel <= select;
          state    <= S_BURST;
        end
      end else begin
        if (accept && in_last) state <= S_IDLE;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    demux_channel_register #(
      .BITS       (BITS),
      .COUNT_BITS (COUNT_BITS)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .load        (load[c]),
      .load_data   (in_data),
      .load_last   (in_last),
      .out_ready   (out_ready[c]),
      .out_valid   (out_valid[c]),
      .out_data    (out_data[c]),
      .out_last    (out_last[c]),
      .free        (free[c])
`ifdef DEMUX_COUNT_EN
      ,
      .clear_count (clear_count),
      .count       (count[c])
`endif
    );
  end

endmodule

// File: tb/tb_n_way_stream_demux.sv
// Directed bench for n_way_stream_demux: a 4-channel instance driven from a
// vector table plus hand sequences, and a 3-channel instance for the
// illegal-select case. Counter checks compile only with DEMUX_COUNT_EN.
module tb_n_way_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Four-channel instance
  logic            v4, l4, rdy4, err4;
  logic [1:0]      sel4;
  logic [3:0]      d4, ordy4, ov4, ol4;
  logic [3:0][3:0] od4;

  // Three-channel instance
  logic            v3, l3, rdy3, err3;
  logic [1:0]      sel3;
  logic [3:0]      d3;
  logic [2:0]      ordy3, ov3, ol3;
  logic [2:0][3:0] od3;

`ifdef DEMUX_COUNT_EN
  logic            clr4, clr3;
  logic [3:0][1:0] cnt4;
  logic [2:0][1:0] cnt3;
`endif

  n_way_stream_demux #(.BITS(4), .CHANNELS(4), .COUNT_BITS(2)) u4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .in_last(l4), .select(sel4), .out_valid(ov4), .out_ready(ordy4),
    .out_data(od4), .out_last(ol4), .error(err4)
`ifdef DEMUX_COUNT_EN
    , .count(cnt4), .clear_count(clr4)
`endif
  );

  n_way_stream_demux #(.BITS(4), .CHANNELS(3), .COUNT_BITS(2)) u3 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
    .in_last(l3), .select(sel3), .out_valid(ov3), .out_ready(ordy3),
    .out_data(od3), .out_last(ol3), .error(err3)
`ifdef DEMUX_COUNT_EN
    , .count(cnt3), .clear_count(clr3)
`endif
  );

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [3:0]  d;
    logic        l;
    logic [3:0]  ordy;
    logic        irdy;   // expected in_ready before the edge
    logic [3:0]  ov;     // expected out_valid after the edge
    logic [3:0]  ol;     // expected out_last after the edge
    logic [15:0] od;     // expected out_data {ch3,ch2,ch1,ch0} after the edge
  } vec_t;

  vec_t vecs [14];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [1:0] sel, input logic [3:0] d,
                        input logic l, input logic [3:0] ordy);
    v4 = v; sel4 = sel; d4 = d; l4 = l; ordy4 = ordy;
  endtask

  task automatic drive3(input logic v, input logic [1:0] sel, input logic [3:0] d,
                        input logic l, input logic [2:0] ordy);
    v3 = v; sel3 = sel; d3 = d; l3 = l; ordy3 = ordy;
  endtask

  initial begin
    // Single beat, 3-beat locked packet, idle check, backpressure with
    // channel 2 flowing, burst stalled on its locked channel.
    vecs[0]  = '{1'b1, 2'd2, 4'hA, 1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0100, 16'h0A00};
    vecs[1]  = '{1'b1, 2'd1, 4'h1, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0100, 16'h0A10};
    vecs[2]  = '{1'b1, 2'd3, 4'h2, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0100, 16'h0A20};
    vecs[3]  = '{1'b1, 2'd3, 4'h3, 1'b1, 4'b1111, 1'b1, 4'b0010, 4'b0110, 16'h0A30};
    vecs[4]  = '{1'b1, 2'd3, 4'h7, 1'b1, 4'b1111, 1'b1, 4'b1000, 4'b1110, 16'h7A30};
    vecs[5]  = '{1'b1, 2'd0, 4'h5, 1'b1, 4'b1110, 1'b1, 4'b0001, 4'b1111, 16'h7A35};
    vecs[6]  = '{1'b1, 2'd0, 4'h6, 1'b1, 4'b1110, 1'b0, 4'b0001, 4'b1111, 16'h7A35};
    vecs[7]  = '{1'b1, 2'd2, 4'h9, 1'b1, 4'b1110, 1'b1, 4'b0101, 4'b1111, 16'h7935};
    vecs[8]  = '{1'b1, 2'd0, 4'h6, 1'b1, 4'b1111, 1'b1, 4'b0001, 4'b1111, 16'h7936};
    vecs[9]  = '{1'b0, 2'd0, 4'h0, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b1111, 16'h7936};
    vecs[10] = '{1'b1, 2'd1, 4'h4, 1'b0, 4'b1111, 1'b1, 4'b0010, 4'b1101, 16'h7946};
    vecs[11] = '{1'b1, 2'd0, 4'h8, 1'b1, 4'b1101, 1'b0, 4'b0010, 4'b1101, 16'h7946};
    vecs[12] = '{1'b1, 2'd0, 4'h8, 1'b1, 4'b1111, 1'b1, 4'b0010, 4'b1111, 16'h7986};
    vecs[13] = '{1'b0, 2'd0, 4'h0, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b1111, 16'h7986};

    reset = 1'b1;
    drive4(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111);
    drive3(1'b0, 2'd0, 4'h0, 1'b0, 3'b111);
`ifdef DEMUX_COUNT_EN
    clr4 = 1'b0;
    clr3 = 1'b0;
`endif
    repeat (2) tick();

    // Reset state
    check("rst_ov4",  32'(ov4),  32'h0);
    check("rst_od4",  32'(od4),  32'h0);
    check("rst_ol4",  32'(ol4),  32'h0);
    check("rst_err4", 32'(err4), 32'h0);
    check("rst_ov3",  32'(ov3),  32'h0);
    check("rst_err3", 32'(err3), 32'h0);
    reset = 1'b0;
    #1;
    check("rst_rdy4", 32'(rdy4), 32'h1);

    // Table-driven vectors on the 4-channel instance
    for (int i = 0; i < 14; i++) begin
      drive4(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].l, vecs[i].ordy);
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(rdy4), 32'(vecs[i].irdy));
      tick();
      check($sformatf("v%0d_out_valid", i), 32'(ov4), 32'(vecs[i].ov));
      check($sformatf("v%0d_out_last", i),  32'(ol4), 32'(vecs[i].ol));
      check($sformatf("v%0d_out_data", i),  32'(od4), 32'(vecs[i].od));
    end

    // Reset mid-packet: channel 3 holds a single beat, channel 0 holds the
    // first beat of an open packet.
    drive4(1'b1, 2'd3, 4'hB, 1'b1, 4'b0000); tick();
    drive4(1'b1, 2'd0, 4'h1, 1'b0, 4'b0000); tick();
    check("mid_pre_ov4", 32'(ov4), 32'h9);
    drive4(1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ov4", 32'(ov4), 32'h0);
    check("mid_rst_od4", 32'(od4), 32'h0);
    check("mid_rst_ol4", 32'(ol4), 32'h0);
    drive4(1'b1, 2'd2, 4'hD, 1'b1, 4'b1111); tick();
    check("mid_idle_ov4", 32'(ov4), 32'h4);
    check("mid_idle_od4", 32'(od4), 32'h0D00);
    drive4(1'b1, 2'd0, 4'hC, 1'b1, 4'b1111); tick();
    check("mid_ch0_ov4", 32'(ov4), 32'h1);
    check("mid_ch0_od4", 32'(od4), 32'h0D0C);
    check("mid_ch0_ol4", 32'(ol4), 32'h5);
    drive4(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111); tick();

    // Illegal select on the 3-channel instance
    drive3(1'b1, 2'd2, 4'h4, 1'b1, 3'b111); tick();
    check("ill_legal_ov3",  32'(ov3),  32'h4);
    check("ill_legal_err3", 32'(err3), 32'h0);
    drive3(1'b1, 2'd3, 4'hF, 1'b0, 3'b111);
    #1;
    check("ill_rdy3", 32'(rdy3), 32'h1);
    tick();
    check("ill_ov3",  32'(ov3),  32'h0);
    check("ill_od3",  32'(od3),  32'h400);
    check("ill_err3", 32'(err3), 32'h1);
    drive3(1'b1, 2'd1, 4'h2, 1'b1, 3'b111); tick();
    check("ill_next_ov3",  32'(ov3),  32'h2);
    check("ill_next_od3",  32'(od3),  32'h420);
    drive3(1'b0, 2'd0, 4'h0, 1'b0, 3'b111);
    repeat (3) tick();
    check("ill_sticky_err3", 32'(err3), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ill_rst_err3", 32'(err3), 32'h0);
    check("ill_rst_ov3",  32'(ov3),  32'h0);

`ifdef DEMUX_COUNT_EN
    // Counters with COUNT_BITS=2: five deliveries wrap to 1; clear beats a handshake.
    clr4 = 1'b1;
    drive4(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111); tick();
    clr4 = 1'b0;
    check("cnt_clear", 32'(cnt4), 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive4(1'b1, 2'd3, 4'(i), 1'b1, 4'b1111); tick();
    end
    drive4(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111); tick();
    check("cnt_wrap", 32'(cnt4), 32'h40);
    drive4(1'b1, 2'd3, 4'hE, 1'b1, 4'b1111); tick();
    check("cnt_hold", 32'(cnt4), 32'h40);
    drive4(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    check("cnt_clr_wins", 32'(cnt4), 32'h0);
    check("cnt_drained",  32'(ov4),  32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
